// File: rtl/issue_id2c_skid.sv
// ID1->ID2 multi-lane issue register with a 2-entry skid buffer.
// The head feeds ID2. The skid entry absorbs one bundle while ID2 stalls.
module issue_id2c_skid #(
  parameter int LANES        = 2,
  parameter int PW           = 256,
  parameter int ZERO_INVALID = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                exception_flush,
  input  logic [LANES-1:0]    in_valid,
  input  logic [LANES*PW-1:0] in_payload,
  output logic                in_ready,
  output logic [LANES-1:0]    out_valid,
  output logic [LANES*PW-1:0] out_payload,
  input  logic                out_ready,
  output logic [1:0]          occupancy
);

  localparam int LW = LANES * PW;

  logic [1:0]       count_q, count_d;
  logic [LANES-1:0] h_vld_q, h_vld_d;
  logic [LW-1:0]    h_pay_q, h_pay_d;
  logic [LANES-1:0] s_vld_q, s_vld_d;
  logic [LW-1:0]    s_pay_q, s_pay_d;

  logic          push;
  logic          pop;
  logic [LW-1:0] in_pay_z;

  // ready comes only from the registered count, never from out_ready
  assign in_ready = (count_q != 2'd2);
  assign push     = in_ready & (|in_valid);
  assign pop      = (count_q != 2'd0) & out_ready;

  assign out_valid   = (count_q != 2'd0) ? h_vld_q : '0;
  assign out_payload = h_pay_q;
  assign occupancy   = count_q;

  // zero the payload of empty lanes so stale data never reaches ID2
  always_comb begin
    in_pay_z = in_payload;
    for (int i = 0; i < LANES; i++) begin
      if ((ZERO_INVALID != 0) && !in_valid[i]) begin
        in_pay_z[i*PW +: PW] = '0;
      end
    end
  end

  // next-state for count, head and skid entries
  always_comb begin
    count_d = count_q;
    h_vld_d = h_vld_q;
    h_pay_d = h_pay_q;
    s_vld_d = s_vld_q;
    s_pay_d = s_pay_q;
    if (exception_flush) begin
      count_d = 2'd0;
      h_vld_d = '0;
      h_pay_d = '0;
      s_vld_d = '0;
      s_pay_d = '0;
    end else if (flush) begin
      s_vld_d = '0;
      s_pay_d = '0;
      if (out_ready) begin
        // head leaves this cycle; nothing else survives
        count_d = 2'd0;
        h_vld_d = '0;
        h_pay_d = '0;
      end else begin
        // ID2 still owns the head, keep it
        count_d = (count_q != 2'd0) ? 2'd1 : 2'd0;
      end
    end else begin
      unique case (count_q)
        2'd0: begin
          if (push) begin
            h_vld_d = in_valid;
            h_pay_d = in_pay_z;
            count_d = 2'd1;
          end
        end
        2'd1: begin
          if (push && !pop) begin
            s_vld_d = in_valid;
            s_pay_d = in_pay_z;
            count_d = 2'd2;
          end else if (push && pop) begin
            h_vld_d = in_valid;
            h_pay_d = in_pay_z;
          end else if (pop) begin
            h_vld_d = '0;
            h_pay_d = '0;
            count_d = 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            h_vld_d = s_vld_q;
            h_pay_d = s_pay_q;
            s_vld_d = '0;
            s_pay_d = '0;
            count_d = 2'd1;
          end
        end
        default: begin
          count_d = 2'd0;
          h_vld_d = '0;
          h_pay_d = '0;
          s_vld_d = '0;
          s_pay_d = '0;
        end
      endcase
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      h_vld_q <= '0;
      h_pay_q <= '0;
      s_vld_q <= '0;
      s_pay_q <= '0;
    end else begin
      count_q <= count_d;
      h_vld_q <= h_vld_d;
      h_pay_q <= h_pay_d;
      s_vld_q <= s_vld_d;
      s_pay_q <= s_pay_d;
    end
  end

  a_count_max : assert property (
    @(posedge clk) disable iff (rst) count_q != 2'd3);
  a_ready_full : assert property (
    @(posedge clk) disable iff (rst) !in_ready |-> count_q == 2'd2);
  a_no_push_full : assert property (
    @(posedge clk) disable iff (rst) !(push && !in_ready));

endmodule
